// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   Arbitrates the 10 board LEDs between the HPS LED PIO and a local pattern
//   generator. In auto mode the HPS takes the LEDs whenever it writes a new
//   value and keeps them for HOLD_STEPS pattern steps after its last write.
//   Switches can instead force HPS ownership, the pattern, or all-off.
//
// Parameters
//   STEP_DIV    clocks per pattern step (>= 2)
//   HOLD_STEPS  steps the HPS keeps ownership after its last write (>= 1)
//
// Ports
//   clk_clk        system clock (shared with the HPS PIO)
//   reset_reset_n  asynchronous active-low reset
//   hps_leds       HPS LED PIO value, already in the clk_clk domain
//   mode_sel       async switches: 00 auto, 01 force HPS, 10 force pattern, 11 off
//   pattern_sel    async switches: 00 scroll, 01 bounce, 10 blink, 11 count
//   pause          async switch, 1 freezes pattern advance
//   leds           registered LED drive
//   owner          registered owner: 00 off, 01 HPS, 10 pattern
//   step_pulse     one-cycle strobe once per step
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter int STEP_DIV   = 5000000,
  parameter int HOLD_STEPS = 30
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [9:0] hps_leds,
  input  logic [1:0] mode_sel,
  input  logic [1:0] pattern_sel,
  input  logic       pause,
  output logic [9:0] leds,
  output logic [1:0] owner,
  output logic       step_pulse
);

  localparam int CNT_W  = $clog2(STEP_DIV);
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_STEPS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // State encoding doubles as the owner code.
  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_HPS     = 2'b01,
    ST_PATTERN = 2'b10
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [9:0]        pattern_reg;
  logic              dir_reg;        // 0 = moving left, 1 = moving right
  logic [9:0]        hps_prev_reg;
  logic [4:0]        sync1_reg;
  logic [4:0]        sync2_reg;
  logic [1:0]        mode_prev_reg;
  logic [1:0]        psel_prev_reg;

  logic [1:0] mode_s;
  logic [1:0] pattern_sel_s;
  logic       pause_s;
  logic       hps_wr;
  logic       enter_pattern;
  logic [9:0] pattern_adv;
  logic       dir_adv;

  // Two-flop synchronizers for all switch inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {pause, pattern_sel, mode_sel};
      sync2_reg <= sync1_reg;
    end
  end

  assign mode_s        = sync2_reg[1:0];
  assign pattern_sel_s = sync2_reg[3:2];
  assign pause_s       = sync2_reg[4];

  // Free-running step prescaler.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign step_pulse = (cnt_reg == CNT_LAST);

  // Any change of the PIO value counts as an HPS write.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hps_prev_reg <= '0;
    end else begin
      hps_prev_reg <= hps_leds;
    end
  end

  assign hps_wr = (hps_leds != hps_prev_reg);

  function automatic logic [9:0] init_pattern(input logic [1:0] sel);
    case (sel)
      2'b10:   return 10'h3FF;
      2'b11:   return 10'h000;
      default: return 10'h001;
    endcase
  endfunction

  // Next value of the running pattern for the selected sequence.
  always_comb begin
    pattern_adv = pattern_reg;
    dir_adv     = dir_reg;
    case (pattern_sel_s)
      2'b00: pattern_adv = {pattern_reg[8:0], pattern_reg[9]};
      2'b01: begin
        // Bounce turns around at each end without repeating the end value.
        if (!dir_reg) begin
          if (pattern_reg == 10'h200) begin
            pattern_adv = 10'h100;
            dir_adv     = 1'b1;
          end else begin
            pattern_adv = pattern_reg << 1;
          end
        end else begin
          if (pattern_reg == 10'h001) begin
            pattern_adv = 10'h002;
            dir_adv     = 1'b0;
          end else begin
            pattern_adv = pattern_reg >> 1;
          end
        end
      end
      2'b10:   pattern_adv = ~pattern_reg;
      default: pattern_adv = pattern_reg + 10'd1;
    endcase
  end

  // Entry into PATTERN from any other state; the pattern restarts on entry.
  always_comb begin
    enter_pattern = 1'b0;
    case (mode_s)
      2'b10: enter_pattern = (state_reg != ST_PATTERN);
      2'b00: begin
        // Leaving force-HPS or off always lands in PATTERN.
        if (mode_prev_reg[0] || state_reg == ST_OFF) begin
          enter_pattern = 1'b1;
        end else if (state_reg == ST_HPS && !hps_wr && step_pulse &&
                     hold_reg <= HOLD_ONE) begin
          // Hold expiry; a write in the same cycle wins and keeps HPS.
          enter_pattern = 1'b1;
        end
      end
      default: enter_pattern = 1'b0;
    endcase
  end

  // Ownership FSM, pattern generator and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg     <= ST_PATTERN;
      hold_reg      <= '0;
      pattern_reg   <= 10'h001;
      dir_reg       <= 1'b0;
      mode_prev_reg <= 2'b00;
      psel_prev_reg <= 2'b00;
      leds          <= 10'h000;
      owner         <= 2'b00;
    end else begin
      mode_prev_reg <= mode_s;
      psel_prev_reg <= pattern_sel_s;

      if (enter_pattern) begin
        state_reg <= ST_PATTERN;
        hold_reg  <= '0;
      end else begin
        case (mode_s)
          2'b01: state_reg <= ST_HPS;
          2'b11: begin
            state_reg <= ST_OFF;
            hold_reg  <= '0;
          end
          2'b00: begin
            if (state_reg == ST_PATTERN && hps_wr) begin
              state_reg <= ST_HPS;
              hold_reg  <= HOLD_LOAD;
            end else if (state_reg == ST_HPS) begin
              if (hps_wr) begin
                hold_reg <= HOLD_LOAD;
              end else if (step_pulse) begin
                hold_reg <= hold_reg - HOLD_ONE;
              end
            end
          end
          default: state_reg <= state_reg;
        endcase
      end

      if (pattern_sel_s != psel_prev_reg || enter_pattern) begin
        pattern_reg <= init_pattern(pattern_sel_s);
        dir_reg     <= 1'b0;
      end else if (state_reg == ST_PATTERN && step_pulse && !pause_s) begin
        pattern_reg <= pattern_adv;
        dir_reg     <= dir_adv;
      end

      case (state_reg)
        ST_HPS:     leds <= hps_leds;
        ST_PATTERN: leds <= pattern_reg;
        default:    leds <= 10'h000;
      endcase
      owner <= state_reg;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//   Directed scenarios with literal expectations, then randomized switches,
//   HPS writes and resets. A behavioural model tracks ownership and a step
//   index per sequence; a negedge process compares every output each cycle.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

  localparam int D = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] hps_leds = '0;
  logic [1:0] mode_sel = '0;
  logic [1:0] pattern_sel = '0;
  logic       pause = 1'b0;
  logic [9:0] leds;
  logic [1:0] owner;
  logic       step_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int step_cyc = 0;
  int step_cyc_prev = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.STEP_DIV(D), .HOLD_STEPS(H)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .hps_leds(hps_leds),
    .mode_sel(mode_sel),
    .pattern_sel(pattern_sel),
    .pause(pause),
    .leds(leds),
    .owner(owner),
    .step_pulse(step_pulse)
  );

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // Pattern is an index k into the selected sequence; ownership 0 off, 1 HPS, 2 pattern.
  function automatic logic [9:0] seq(input int ps, input int k);
    logic [9:0] one;
    int p;
    one = 10'd1;
    case (ps)
      0: return one << (k % 10);
      1: begin
        p = k % 18;
        if (p > 9) p = 18 - p;
        return one << p;
      end
      2: return ((k % 2) == 0) ? 10'h3FF : 10'h000;
      default: return 10'(k % 1024);
    endcase
  endfunction

  int m_hm[4];
  int m_hp[4];
  int m_hz[3];
  int m_e, m_st, m_hold, m_k;
  logic [9:0] m_pat, m_hps_prev;
  logic [9:0] exp_leds;
  logic [1:0] exp_owner;
  logic       exp_step;

  always @(posedge clk or negedge rst_n) begin
    int md, mdp, ps, psp, pz, old_st;
    bit stp, wr, enter;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_hm[i] = 0; m_hp[i] = 0; end
      for (int i = 0; i < 3; i++) m_hz[i] = 0;
      m_e = 0; m_st = 2; m_hold = 0; m_k = 0;
      m_pat = 10'h001; m_hps_prev = 10'h000;
      exp_leds = 10'h000; exp_owner = 2'b00; exp_step = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) begin m_hm[i] = m_hm[i-1]; m_hp[i] = m_hp[i-1]; end
      for (int i = 2; i > 0; i--) m_hz[i] = m_hz[i-1];
      m_hm[0] = int'(mode_sel);
      m_hp[0] = int'(pattern_sel);
      m_hz[0] = int'(pause);
      // Switch values seen by the logic lag the pins by two samples.
      md = m_hm[2]; mdp = m_hm[3]; ps = m_hp[2]; psp = m_hp[3]; pz = m_hz[2];
      stp = ((m_e % D) == D - 1);
      wr  = (hps_leds != m_hps_prev);

      exp_owner = 2'(m_st);
      exp_leds  = (m_st == 1) ? hps_leds : (m_st == 2) ? m_pat : 10'h000;

      old_st = m_st;
      enter = 1'b0;
      case (md)
        1: m_st = 1;
        2: if (m_st != 2) enter = 1'b1;
        3: begin m_st = 0; m_hold = 0; end
        default: begin
          if (mdp == 1 || mdp == 3 || m_st == 0) enter = 1'b1;
          else if (m_st == 2 && wr) begin m_st = 1; m_hold = H; end
          else if (m_st == 1) begin
            if (wr) m_hold = H;
            else if (stp) begin
              m_hold = m_hold - 1;
              if (m_hold <= 0) begin m_hold = 0; enter = 1'b1; end
            end
          end
        end
      endcase
      if (enter) m_st = 2;

      if (ps != psp || enter) m_k = 0;
      else if (old_st == 2 && stp && pz == 0) m_k = m_k + 1;
      m_pat = seq(ps, m_k);

      m_hps_prev = hps_leds;
      m_e = m_e + 1;
      exp_step = ((m_e % D) == D - 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (leds !== exp_leds) begin
        fails++;
        $display("FAIL model_leds t=%0t: got %h, expected %h", $time, leds, exp_leds);
      end
      tests++;
      if (owner !== exp_owner) begin
        fails++;
        $display("FAIL model_owner t=%0t: got %b, expected %b", $time, owner, exp_owner);
      end
      tests++;
      if (step_pulse !== exp_step) begin
        fails++;
        $display("FAIL model_step t=%0t: got %b, expected %b", $time, step_pulse, exp_step);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
    $display("[TB] check %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_step();
    int n;
    n = 0;
    do begin
      @(posedge clk); #6;
      n++;
    end while (!step_pulse && n < 40);
    tests++;
    if (!step_pulse) begin
      fails++;
      $display("FAIL step_wait t=%0t: no step_pulse within %0d cycles", $time, n);
    end
    step_cyc_prev = step_cyc;
    step_cyc = cyc;
  endtask

  task automatic two_edges();
    repeat (2) begin @(posedge clk); #6; end
  endtask

  logic [9:0] scroll_tab [11] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                                  10'h080, 10'h100, 10'h200, 10'h001, 10'h002};
  logic [9:0] bounce_tab [19] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                                  10'h080, 10'h100, 10'h200, 10'h100, 10'h080, 10'h040,
                                  10'h020, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001,
                                  10'h002};

  initial begin
    int n;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset release and scroll sequence.
    @(posedge clk); #6;
    check("release_owner", 32'(owner), 32'h2);
    check("release_leds", 32'(leds), 32'h001);
    check("release_step", 32'(step_pulse), 32'h0);
    for (int i = 0; i < 11; i++) begin
      wait_step();
      if (i > 0) check("step_period", 32'(step_cyc - step_cyc_prev), 32'd4);
      two_edges();
      check("scroll_leds", 32'(leds), 32'(scroll_tab[i]));
    end

    // HPS write takes ownership, then expires after HOLD_STEPS steps.
    wait_step();
    hps_leds = 10'h2AA;
    two_edges();
    check("hps_owner", 32'(owner), 32'h1);
    check("hps_leds", 32'(leds), 32'h2AA);
    wait_step(); wait_step(); two_edges();
    check("hold_2steps_owner", 32'(owner), 32'h1);
    wait_step(); two_edges();
    check("expire_owner", 32'(owner), 32'h2);
    check("expire_leds", 32'(leds), 32'h001);

    // Write coinciding with hold expiry keeps HPS and reloads the hold.
    wait_step();
    hps_leds = 10'h155;
    two_edges();
    check("hps2_owner", 32'(owner), 32'h1);
    wait_step(); wait_step(); wait_step();
    hps_leds = 10'h0CC;
    two_edges();
    check("wr_prio_owner", 32'(owner), 32'h1);
    check("wr_prio_leds", 32'(leds), 32'h0CC);
    wait_step(); wait_step(); two_edges();
    check("reload_owner", 32'(owner), 32'h1);
    wait_step(); two_edges();
    check("reload_expire_owner", 32'(owner), 32'h2);

    // Bounce sequence.
    wait_step();
    pattern_sel = 2'b01;
    wait_step();
    check("bounce_init", 32'(leds), 32'h001);
    for (int i = 0; i < 19; i++) begin
      if (i > 0) wait_step();
      two_edges();
      check("bounce_leds", 32'(leds), 32'(bounce_tab[i]));
    end

    // Forced off, then auto with pause.
    mode_sel = 2'b11;
    n = 0;
    do begin @(posedge clk); #6; n++; end while (!(owner == 2'b00 && leds == 10'h000) && n < 4);
    check("off_owner", 32'(owner), 32'h0);
    check("off_leds", 32'(leds), 32'h000);
    mode_sel = 2'b00;
    pause = 1'b1;
    repeat (6) begin @(posedge clk); #6; end
    for (int i = 0; i < 5; i++) begin
      wait_step();
      check("pause_leds", 32'(leds), 32'h001);
    end
    pause = 1'b0;

    // Reset while in HPS with hold = 2.
    wait_step();
    hps_leds = 10'h3C3;
    two_edges();
    check("hps3_owner", 32'(owner), 32'h1);
    wait_step(); two_edges();
    rst_n = 1'b0;
    #1;
    check("rst_leds", 32'(leds), 32'h000);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_step", 32'(step_pulse), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #6;
    check("rst_rel_owner", 32'(owner), 32'h2);
    check("rst_rel_leds", 32'(leds), 32'h001);

    // Randomized phase, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(39) == 0) hps_leds = 10'($urandom);
      if ($urandom_range(99) == 0) mode_sel = 2'($urandom);
      if ($urandom_range(59) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(79) == 0) pause = ~pause;
      if ($urandom_range(999) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end

    @(posedge clk); #6;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
